// File: rtl/ext_mem_ctrl.sv
`default_nettype none
// =============================================================================
// ext_mem_ctrl : ready/valid front end for a synchronous external memory with
//                round-robin single-port arbitration, read pipeline, counters.
// Revision     : 1.0
// =============================================================================
module ext_mem_ctrl #(
    parameter int  DATA_WIDTH   = 32,
    parameter int  HEIGHT       = 1 << 20,
    parameter int  READ_LATENCY = 1,
    parameter int  SINGLE_PORT  = 1,
    parameter int  CNT_WIDTH    = 48,
    localparam int AW           = $clog2(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [AW-1:0]         mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_qout,
    output logic [AW-1:0]         mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_write_en,
    input  logic                  clear_counters,
    output logic [CNT_WIDTH-1:0]  rd_words,
    output logic [CNT_WIDTH-1:0]  wr_words,
    output logic [CNT_WIDTH-1:0]  bits_total,
    output logic [CNT_WIDTH-1:0]  conflict_cycles
);

    localparam logic [0:0] GNT_RD = 1'b0;
    localparam logic [0:0] GNT_WR = 1'b1;

    localparam int INC_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int SUM_W = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                    run_q, run_d;
    logic [0:0]              last_grant_q, last_grant_d;
    logic                    rd_grant, wr_grant, conflict;
    logic                    rd_acc, wr_acc;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   rsp_data_raw;
    logic [INC_W-1:0]        rd_inc, wr_inc, conf_inc, bits_inc;
    logic [CNT_WIDTH-1:0]    rd_words_q, rd_words_d;
    logic [CNT_WIDTH-1:0]    wr_words_q, wr_words_d;
    logic [CNT_WIDTH-1:0]    bits_total_q, bits_total_d;
    logic [CNT_WIDTH-1:0]    conflict_cycles_q, conflict_cycles_d;

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] base,
        input logic [INC_W-1:0]     inc
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        sat_add = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
    endfunction

    // Readies stay low until the first edge after reset release.
    always_comb begin
        run_d        = 1'b1;
        rd_grant     = 1'b0;
        wr_grant     = 1'b0;
        conflict     = 1'b0;
        last_grant_d = last_grant_q;
        if (run_q) begin
            if (SINGLE_PORT == 0) begin
                rd_grant = 1'b1;
                wr_grant = 1'b1;
            end else begin
                conflict = rd_req_valid && wr_req_valid;
                rd_grant = !wr_req_valid || (last_grant_q == GNT_WR);
                wr_grant = !rd_req_valid || (last_grant_q == GNT_RD);
                if (conflict) begin
                    last_grant_d = rd_grant ? GNT_RD : GNT_WR;
                end
            end
        end
        rd_acc = rd_req_valid && rd_grant;
        wr_acc = wr_req_valid && wr_grant;
    end

    always_comb begin
        rd_inc            = INC_W'(rd_acc);
        wr_inc            = INC_W'(wr_acc);
        conf_inc          = INC_W'(conflict);
        bits_inc          = (rd_acc ? INC_W'(DATA_WIDTH) : '0)
                          + (wr_acc ? INC_W'(DATA_WIDTH) : '0);
        rd_words_d        = sat_add(clear_counters ? '0 : rd_words_q, rd_inc);
        wr_words_d        = sat_add(clear_counters ? '0 : wr_words_q, wr_inc);
        bits_total_d      = sat_add(clear_counters ? '0 : bits_total_q, bits_inc);
        conflict_cycles_d = sat_add(clear_counters ? '0 : conflict_cycles_q, conf_inc);
    end

    // Memory returns data one edge after the address; deeper latencies add stages.
    generate
        if (READ_LATENCY == 1) begin : g_lat_one
            assign vld_d        = rd_acc;
            assign rsp_data_raw = mem_qout;
        end else begin : g_lat_multi
            logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY-1];
            assign vld_d = {vld_q[READ_LATENCY-2:0], rd_acc};
            always_ff @(posedge clk) begin
                dat_q[0] <= mem_qout;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
            assign rsp_data_raw = dat_q[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            run_q             <= 1'b0;
            last_grant_q      <= GNT_WR;
            vld_q             <= '0;
            rd_words_q        <= '0;
            wr_words_q        <= '0;
            bits_total_q      <= '0;
            conflict_cycles_q <= '0;
        end else begin
            run_q             <= run_d;
            last_grant_q      <= last_grant_d;
            vld_q             <= vld_d;
            rd_words_q        <= rd_words_d;
            wr_words_q        <= wr_words_d;
            bits_total_q      <= bits_total_d;
            conflict_cycles_q <= conflict_cycles_d;
        end
    end

    assign rd_req_ready    = rd_grant;
    assign wr_req_ready    = wr_grant;
    assign mem_read_addr   = rd_addr;
    assign mem_write_addr  = wr_addr;
    assign mem_din         = wr_data;
    assign mem_write_en    = wr_acc;
    assign rd_rsp_valid    = vld_q[READ_LATENCY-1];
    assign rd_rsp_data     = rd_rsp_valid ? rsp_data_raw : '0;
    assign rd_words        = rd_words_q;
    assign wr_words        = wr_words_q;
    assign bits_total      = bits_total_q;
    assign conflict_cycles = conflict_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_ctrl.sv
`default_nettype none
// =============================================================================
// tb_ext_mem_ctrl : four controller configurations, each with its own memory,
//                   reference model and every-cycle compare, plus directed tests.
// Revision        : 1.0
// =============================================================================
module tb_ext_mem_ctrl;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int HT = 64;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    int   tcyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) tcyc <= tcyc + 1;

    logic          rv  [NI];
    logic          wv  [NI];
    logic          clr [NI];
    logic [AW-1:0] ra  [NI];
    logic [AW-1:0] wa  [NI];
    logic [DW-1:0] wd  [NI];

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h required=%0h at t=%0t", nm, g, act, exp, $time);
        end
    endtask

    // inst0: dual/lat1, inst1: single/lat1, inst2: dual/lat3, inst3: single/lat4/cnt4
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int SP  = (g == 1 || g == 3) ? 1 : 0;
        localparam int LAT = (g == 2) ? 3 : ((g == 3) ? 4 : 1);
        localparam int CW  = (g == 3) ? 4 : 48;
        localparam logic [63:0] MAXC = (64'd1 << CW) - 64'd1;

        logic          rd_req_ready, wr_req_ready, rd_rsp_valid, mem_write_en;
        logic [DW-1:0] rd_rsp_data, mem_din, mem_qout;
        logic [AW-1:0] mem_read_addr, mem_write_addr;
        logic [CW-1:0] rd_words, wr_words, bits_total, conflict_cycles;

        logic [DW-1:0] mem [HT];
        logic [DW-1:0] img [HT];

        bit          run = 1'b0;
        bit          last_w = 1'b1;
        int          cyc = 0;
        logic [63:0] n_rd = 0, n_wr = 0, n_bits = 0, n_conf = 0;
        int          due_q [$];
        logic [DW-1:0] dat_q [$];
        bit          acc_r, acc_w, both;

        int            rsp_n = 0;
        int            we_n  = 0;
        logic [DW-1:0] rsp_dat [32];
        int            rsp_cyc [32];
        bit            c_rr, c_wr, c_v;

        ext_mem_ctrl #(
            .DATA_WIDTH  (DW),
            .HEIGHT      (HT),
            .READ_LATENCY(LAT),
            .SINGLE_PORT (SP),
            .CNT_WIDTH   (CW)
        ) u_dut (
            .clk            (clk),
            .arst_n_in      (arst_n),
            .rd_req_valid   (rv[g]),
            .rd_req_ready   (rd_req_ready),
            .rd_addr        (ra[g]),
            .rd_rsp_valid   (rd_rsp_valid),
            .rd_rsp_data    (rd_rsp_data),
            .wr_req_valid   (wv[g]),
            .wr_req_ready   (wr_req_ready),
            .wr_addr        (wa[g]),
            .wr_data        (wd[g]),
            .mem_read_addr  (mem_read_addr),
            .mem_qout       (mem_qout),
            .mem_write_addr (mem_write_addr),
            .mem_din        (mem_din),
            .mem_write_en   (mem_write_en),
            .clear_counters (clr[g]),
            .rd_words       (rd_words),
            .wr_words       (wr_words),
            .bits_total     (bits_total),
            .conflict_cycles(conflict_cycles)
        );

        initial begin
            for (int i = 0; i < HT; i++) begin
                mem[i] = 32'hC0DE_0000 + i;
                img[i] = 32'hC0DE_0000 + i;
            end
        end

        // External memory: registered read, read-before-write on the same edge.
        always @(posedge clk) begin
            mem_qout <= mem[mem_read_addr];
            if (mem_write_en) mem[mem_write_addr] <= mem_din;
        end

        // Reference model: grant rule, response schedule, memory image, counters.
        always @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                run = 1'b0; last_w = 1'b1;
                n_rd = 0; n_wr = 0; n_bits = 0; n_conf = 0;
                due_q.delete(); dat_q.delete();
            end else begin
                cyc++;
                if (run) begin
                    both  = (SP == 1) && rv[g] && wv[g];
                    acc_r = rv[g] && (SP == 0 || !wv[g] || last_w);
                    acc_w = wv[g] && (SP == 0 || !rv[g] || !last_w);
                    if (both) last_w = acc_w;
                    if (acc_r) begin
                        due_q.push_back(cyc + LAT - 1);
                        dat_q.push_back(img[ra[g]]);
                    end
                    if (acc_w) img[wa[g]] = wd[g];
                    if (clr[g]) begin
                        n_rd = 0; n_wr = 0; n_bits = 0; n_conf = 0;
                    end
                    n_rd   = (n_rd + acc_r > MAXC) ? MAXC : n_rd + acc_r;
                    n_wr   = (n_wr + acc_w > MAXC) ? MAXC : n_wr + acc_w;
                    n_conf = (n_conf + both > MAXC) ? MAXC : n_conf + both;
                    n_bits = (n_bits + DW * (acc_r + acc_w) > MAXC) ? MAXC
                           : n_bits + DW * (acc_r + acc_w);
                end
                run = 1'b1;
            end
        end

        always @(negedge clk) begin
            c_rr = run && (SP == 0 || !wv[g] || last_w);
            c_wr = run && (SP == 0 || !rv[g] || !last_w);
            c_v  = (due_q.size() > 0) && (due_q[0] == cyc);
            chk("rd_req_ready", g, 64'(rd_req_ready), 64'(c_rr));
            chk("wr_req_ready", g, 64'(wr_req_ready), 64'(c_wr));
            chk("mem_write_en", g, 64'(mem_write_en), 64'(wv[g] && c_wr));
            chk("rd_rsp_valid", g, 64'(rd_rsp_valid), 64'(c_v));
            if (c_v) begin
                chk("rd_rsp_data", g, 64'(rd_rsp_data), 64'(dat_q[0]));
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (!run) chk("rd_rsp_data_rst", g, 64'(rd_rsp_data), 64'd0);
            if (rv[g] && c_rr) chk("mem_read_addr", g, 64'(mem_read_addr), 64'(ra[g]));
            if (wv[g] && c_wr) begin
                chk("mem_write_addr", g, 64'(mem_write_addr), 64'(wa[g]));
                chk("mem_din", g, 64'(mem_din), 64'(wd[g]));
            end
            chk("rd_words", g, 64'(rd_words), n_rd);
            chk("wr_words", g, 64'(wr_words), n_wr);
            chk("bits_total", g, 64'(bits_total), n_bits);
            chk("conflict_cycles", g, 64'(conflict_cycles), n_conf);
            if (rd_rsp_valid && rsp_n < 32) begin
                rsp_dat[rsp_n] = rd_rsp_data;
                rsp_cyc[rsp_n] = tcyc;
                rsp_n++;
            end
            if (mem_write_en) we_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n0, acc0;

    initial begin
        arst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rv[i] = 1'b0; wv[i] = 1'b0; clr[i] = 1'b0;
            ra[i] = '0;   wa[i] = '0;   wd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd_ready", 0, 64'(g_inst[0].rd_req_ready), 64'd0);
        chk("rst_wr_ready", 3, 64'(g_inst[3].wr_req_ready), 64'd0);
        chk("rst_rsp_data", 2, 64'(g_inst[2].rd_rsp_data), 64'd0);
        chk("rst_bits", 0, 64'(g_inst[0].bits_total), 64'd0);
        arst_n = 1'b1;
        #1;
        chk("release_rd_ready", 0, 64'(g_inst[0].rd_req_ready), 64'd0);
        step();
        chk("run_rd_ready", 0, 64'(g_inst[0].rd_req_ready), 64'd1);

        // Dual mode: write then read back.
        wv[0] = 1'b1; wa[0] = 6'd5; wd[0] = 32'hDEAD_BEEF;
        step();
        wv[0] = 1'b0; rv[0] = 1'b1; ra[0] = 6'd5;
        step();
        rv[0] = 1'b0;
        chk("wr_rd_valid", 0, 64'(g_inst[0].rd_rsp_valid), 64'd1);
        chk("wr_rd_data", 0, 64'(g_inst[0].rd_rsp_data), 64'hDEAD_BEEF);
        chk("wr_rd_wr_words", 0, 64'(g_inst[0].wr_words), 64'd1);
        chk("wr_rd_rd_words", 0, 64'(g_inst[0].rd_words), 64'd1);
        chk("wr_rd_bits", 0, 64'(g_inst[0].bits_total), 64'd64);

        // Same-address collision: read sees old data, next read sees new.
        wv[0] = 1'b1; wa[0] = 6'd9; wd[0] = 32'h1;
        step();
        rv[0] = 1'b1; ra[0] = 6'd9; wd[0] = 32'h2;
        step();
        rv[0] = 1'b0; wv[0] = 1'b0;
        chk("collide_old", 0, 64'(g_inst[0].rd_rsp_data), 64'h1);
        rv[0] = 1'b1;
        step();
        rv[0] = 1'b0;
        chk("collide_new", 0, 64'(g_inst[0].rd_rsp_data), 64'h2);
        chk("collide_bits", 0, 64'(g_inst[0].bits_total), 64'd192);

        // Clear in the same cycle as an accepted write.
        clr[0] = 1'b1; wv[0] = 1'b1; wa[0] = 6'd20; wd[0] = 32'd77;
        step();
        clr[0] = 1'b0; wv[0] = 1'b0;
        chk("clr_wr_words", 0, 64'(g_inst[0].wr_words), 64'd1);
        chk("clr_rd_words", 0, 64'(g_inst[0].rd_words), 64'd0);
        chk("clr_bits", 0, 64'(g_inst[0].bits_total), 64'd32);

        // Single mode: sustained conflict alternates R,W,R,W.
        n0 = g_inst[1].we_n;
        rv[1] = 1'b1; wv[1] = 1'b1; ra[1] = 6'd3; wa[1] = 6'd4; wd[1] = 32'h55;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("conf_rd_grant", 1, 64'(g_inst[1].rd_req_ready), 64'(k % 2 == 0));
            chk("conf_wr_grant", 1, 64'(g_inst[1].wr_req_ready), 64'(k % 2 == 1));
            chk("conf_we", 1, 64'(g_inst[1].mem_write_en), 64'(k % 2 == 1));
            step();
        end
        rv[1] = 1'b0; wv[1] = 1'b0;
        chk("conf_cycles", 1, 64'(g_inst[1].conflict_cycles), 64'd4);
        chk("conf_rd_words", 1, 64'(g_inst[1].rd_words), 64'd2);
        chk("conf_wr_words", 1, 64'(g_inst[1].wr_words), 64'd2);
        chk("conf_we_count", 1, 64'(g_inst[1].we_n - n0), 64'd2);

        // Latency 3: eight back-to-back reads of addr 0..7.
        n0 = g_inst[2].rsp_n;
        acc0 = 0;
        rv[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ra[2] = 6'(k);
            step();
            if (k == 0) acc0 = tcyc;
        end
        rv[2] = 1'b0;
        repeat (6) step();
        chk("lat_rsp_count", 2, 64'(g_inst[2].rsp_n - n0), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("lat_rsp_cycle", 2, 64'(g_inst[2].rsp_cyc[n0 + i]), 64'(acc0 + 2 + i));
            chk("lat_rsp_data", 2, 64'(g_inst[2].rsp_dat[n0 + i]), 64'(32'hC0DE_0000 + i));
        end

        // Saturation at CNT_WIDTH=4.
        rv[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ra[3] = 6'(k % 8);
            step();
        end
        rv[3] = 1'b0;
        repeat (5) step();
        chk("sat_rd_words", 3, 64'(g_inst[3].rd_words), 64'd15);
        chk("sat_bits", 3, 64'(g_inst[3].bits_total), 64'd15);
        chk("sat_wr_words", 3, 64'(g_inst[3].wr_words), 64'd0);

        // Reset with two reads in flight at latency 4.
        n0 = g_inst[3].rsp_n;
        rv[3] = 1'b1; ra[3] = 6'd1;
        step();
        ra[3] = 6'd2;
        step();
        rv[3] = 1'b0;
        #2;
        arst_n = 1'b0;
        rv[3] = 1'b1; wv[3] = 1'b1;
        #1;
        chk("rstmid_rd_ready", 3, 64'(g_inst[3].rd_req_ready), 64'd0);
        chk("rstmid_wr_ready", 3, 64'(g_inst[3].wr_req_ready), 64'd0);
        chk("rstmid_we", 3, 64'(g_inst[3].mem_write_en), 64'd0);
        chk("rstmid_rd_words", 3, 64'(g_inst[3].rd_words), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rv[3] = 1'b0; wv[3] = 1'b0;
        arst_n = 1'b1;
        repeat (8) step();
        chk("rstmid_no_rsp", 3, 64'(g_inst[3].rsp_n - n0), 64'd0);
        chk("rstmid_rd_words_after", 3, 64'(g_inst[3].rd_words), 64'd0);
        chk("rstmid_bits_after", 3, 64'(g_inst[3].bits_total), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
